// File: rtl/magnet_sequencer.sv
// Electromagnet SR-latch sequencer: arbitrates auto/manual grab and release commands,
// times mutually exclusive set/reset pulses, confirms mag_on and limits hold time.
module magnet_sequencer #(
    parameter int CW           = 16,
    parameter int SETTLE_CYC   = 8,
    parameter int RELEASE_CYC  = 8,
    parameter int COOL_CYC     = 16,
    parameter int MAX_HOLD_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic grab_req_a,
    input  logic rel_req_a,
    input  logic grab_req_m,
    input  logic rel_req_m,
    input  logic clear_fault,
    input  logic mag_on,
    output logic mag_set,
    output logic mag_reset,
    output logic busy,
    output logic holding,
    output logic grant_m,
    output logic done,
    output logic fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENERGIZE,
        S_HOLD,
        S_RELEASE,
        S_COOL
    } state_t;

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYC - 1);
    localparam logic [CW-1:0] COOL_LAST    = CW'(COOL_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(MAX_HOLD_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_mag_set;
    logic          r_mag_reset;
    logic          r_busy;
    logic          r_holding;
    logic          r_grant_m;
    logic          r_done;
    logic          r_fault;
    logic          w_grant_m_nxt;
    logic          w_done_nxt;
    logic          w_fault_evt;

    // A requester raising grab and release together issues no command.
    logic w_grab_a, w_rel_a, w_grab_m, w_rel_m;
    assign w_grab_a = grab_req_a & ~rel_req_a;
    assign w_rel_a  = rel_req_a  & ~grab_req_a;
    assign w_grab_m = grab_req_m & ~rel_req_m;
    assign w_rel_m  = rel_req_m  & ~grab_req_m;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_m_nxt = r_grant_m;
        w_done_nxt    = 1'b0;
        w_fault_evt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grab_a || w_grab_m) begin
                    w_state_nxt   = S_ENERGIZE;
                    w_grant_m_nxt = ~w_grab_a;
                end
            end
            S_ENERGIZE: begin
                if (r_cnt == SETTLE_LAST) begin
                    if (mag_on) begin
                        w_state_nxt = S_HOLD;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RELEASE;
                        w_fault_evt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                // Timeout and lost feedback are not accepted commands: grant_m keeps its value.
                if (r_cnt == HOLD_LAST || !mag_on) begin
                    w_state_nxt = S_RELEASE;
                    w_fault_evt = 1'b1;
                end else if (w_rel_a || w_rel_m) begin
                    w_state_nxt   = S_RELEASE;
                    w_grant_m_nxt = ~w_rel_a;
                end
            end
            S_RELEASE: begin
                if (r_cnt == RELEASE_LAST) begin
                    w_state_nxt = S_COOL;
                    w_done_nxt  = 1'b1;
                end
            end
            S_COOL: begin
                if (r_cnt == COOL_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_RELEASE;
        endcase

        if (w_state_nxt != r_state || r_state == S_IDLE) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RELEASE;
            r_cnt       <= '0;
            r_mag_set   <= 1'b0;
            r_mag_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_holding   <= 1'b0;
            r_grant_m   <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mag_set   <= (w_state_nxt == S_ENERGIZE);
            r_mag_reset <= (w_state_nxt == S_RELEASE);
            r_busy      <= !(w_state_nxt == S_IDLE || w_state_nxt == S_HOLD);
            r_holding   <= (w_state_nxt == S_HOLD);
            r_grant_m   <= w_grant_m_nxt;
            r_done      <= w_done_nxt;
            if (w_fault_evt) begin
                r_fault <= 1'b1;
            end else if (clear_fault) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign mag_set   = r_mag_set;
    assign mag_reset = r_mag_reset;
    assign busy      = r_busy;
    assign holding   = r_holding;
    assign grant_m   = r_grant_m;
    assign done      = r_done;
    assign fault     = r_fault;

endmodule

// File: tb/tb_magnet_sequencer.sv
// Directed bench for magnet_sequencer with a behavioural SR latch driving mag_on.
module tb_magnet_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic grab_req_a = 1'b0, rel_req_a = 1'b0, grab_req_m = 1'b0, rel_req_m = 1'b0;
    logic clear_fault = 1'b0;
    logic mag_on;
    logic mag_set, mag_reset, busy, holding, grant_m, done, fault;

    logic r_latch = 1'b0;
    logic latch_dead = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    magnet_sequencer #(
        .CW(16), .SETTLE_CYC(8), .RELEASE_CYC(8), .COOL_CYC(16), .MAX_HOLD_CYC(20)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .grab_req_a(grab_req_a), .rel_req_a(rel_req_a),
        .grab_req_m(grab_req_m), .rel_req_m(rel_req_m),
        .clear_fault(clear_fault), .mag_on(mag_on),
        .mag_set(mag_set), .mag_reset(mag_reset), .busy(busy), .holding(holding),
        .grant_m(grant_m), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    // latch_dead models a coil that never pulls in (or drops out).
    always @(posedge clk) begin
        if (mag_set) r_latch <= 1'b1;
        else if (mag_reset) r_latch <= 1'b0;
    end
    assign mag_on = r_latch & ~latch_dead;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) check("set_reset_exclusive", 32'(mag_set & mag_reset), 0);

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic sel(input int k);
        case (k)
            0:       return mag_set;
            1:       return mag_reset;
            2:       return busy & ~mag_set & ~mag_reset;
            default: return holding;
        endcase
    endfunction

    // Length of the run of sel(k)==1 that includes the current sample; bounded.
    task automatic run_len(input int k, output int len);
        len = 1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (sel(k)) len++;
            else return;
        end
    endtask

    task automatic finish_release();
        int m;
        if (mag_reset) run_len(1, m);
        run_len(2, m);
        check("back_to_idle", 32'(busy), 0);
    endtask

    initial begin
        // 1: reset release
        #3 rst_n = 1'b0;
        #1;
        check("rst_mag_reset", 32'(mag_reset), 1);
        check("rst_mag_set", 32'(mag_set), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_holding", 32'(holding), 0);
        check("rst_grant_m", 32'(grant_m), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fault", 32'(fault), 0);
        tick(); tick();
        rst_n = 1'b1;
        run_len(1, n);
        check("rst_release_len", 32'(n), 8);
        run_len(2, n);
        check("rst_cool_len", 32'(n), 16);
        check("idle_busy", 32'(busy), 0);

        // IDLE ignores releases and self-conflicting requests
        rel_req_a = 1'b1; tick(); rel_req_a = 1'b0;
        check("idle_ignore_rel", 32'(busy), 0);
        grab_req_a = 1'b1; rel_req_a = 1'b1; tick(); grab_req_a = 1'b0; rel_req_a = 1'b0;
        check("idle_both_high", 32'(busy), 0);

        // 2: manual grab
        grab_req_m = 1'b1; tick(); grab_req_m = 1'b0;
        check("grab_mag_set", 32'(mag_set), 1);
        check("grab_grant_m", 32'(grant_m), 1);
        run_len(0, n);
        check("settle_len", 32'(n), 8);
        check("hold_holding", 32'(holding), 1);
        check("hold_done", 32'(done), 1);
        check("hold_busy", 32'(busy), 0);
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("hold_still", 32'(holding), 1);
        rel_req_a = 1'b1; tick(); rel_req_a = 1'b0;
        check("rel_auto_grant", 32'(grant_m), 0);
        finish_release();

        // 3: simultaneous grabs, then manual release
        grab_req_a = 1'b1; grab_req_m = 1'b1; tick(); grab_req_a = 1'b0; grab_req_m = 1'b0;
        check("simul_grant_auto", 32'(grant_m), 0);
        run_len(0, n);
        check("simul_holding", 32'(holding), 1);
        grab_req_m = 1'b1; tick(); grab_req_m = 1'b0;
        check("hold_ignore_grab", 32'(holding), 1);
        rel_req_m = 1'b1; tick(); rel_req_m = 1'b0;
        check("rel_mag_reset", 32'(mag_reset), 1);
        check("rel_grant_m", 32'(grant_m), 1);
        run_len(1, n);
        check("release_len", 32'(n), 8);
        check("release_done", 32'(done), 1);
        run_len(2, n);
        check("cool_len", 32'(n), 16);

        // 4: grab not confirmed
        latch_dead = 1'b1;
        grab_req_a = 1'b1; tick(); grab_req_a = 1'b0;
        run_len(0, n);
        check("fail_settle_len", 32'(n), 8);
        check("fail_fault", 32'(fault), 1);
        check("fail_mag_reset", 32'(mag_reset), 1);
        check("fail_holding", 32'(holding), 0);
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        check("clear_fault", 32'(fault), 0);
        run_len(1, n);
        check("fail_release_done", 32'(done), 1);
        run_len(2, n);
        clear_fault = 1'b1;
        grab_req_a = 1'b1; tick(); grab_req_a = 1'b0;
        run_len(0, n);
        check("set_beats_clear", 32'(fault), 1);
        clear_fault = 1'b0; tick();
        check("fault_sticky", 32'(fault), 1);
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        check("clear_again", 32'(fault), 0);
        tick();
        check("cleared_stays", 32'(fault), 0);
        latch_dead = 1'b0;
        finish_release();

        // 5: hold timeout
        grab_req_a = 1'b1; tick(); grab_req_a = 1'b0;
        run_len(0, n);
        run_len(3, n);
        check("hold_timeout_len", 32'(n), 20);
        check("timeout_fault", 32'(fault), 1);
        check("timeout_mag_reset", 32'(mag_reset), 1);
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        finish_release();

        // mag_on lost while holding
        grab_req_m = 1'b1; tick(); grab_req_m = 1'b0;
        run_len(0, n);
        tick(); tick();
        latch_dead = 1'b1; tick();
        check("drop_fault", 32'(fault), 1);
        check("drop_mag_reset", 32'(mag_reset), 1);
        latch_dead = 1'b0;
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        finish_release();

        // 6: reset in ENERGIZE cycle 3
        grab_req_m = 1'b1; tick(); grab_req_m = 1'b0;
        tick(); tick(); tick();
        check("pre_rst_mag_set", 32'(mag_set), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_mag_set", 32'(mag_set), 0);
        check("async_mag_reset", 32'(mag_reset), 1);
        check("async_busy", 32'(busy), 1);
        check("async_grant_m", 32'(grant_m), 0);
        tick();
        rst_n = 1'b1;
        run_len(1, n);
        check("rst2_release_len", 32'(n), 8);
        run_len(2, n);
        check("rst2_cool_len", 32'(n), 16);
        check("rst2_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
